// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand feed sequencer and its datapath.
package sa_pkg;

    localparam int SA_DIM      = 3;
    localparam int SA_FEED_LEN = SA_DIM * SA_DIM;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FEED   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } sa_state_e;

    // Skewed operand-mux schedule indexed by feed beat; beats 9..15 are unused and map to 0.
    // Entry order in the concatenation is 15 down to 0.
    localparam logic [15:0][1:0] SA_SEL_LUT = {
        2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,   // 15..9
        2'd2, 2'd2, 2'd1, 2'd2, 2'd1,               // 8..4
        2'd0, 2'd1, 2'd0, 2'd0                      // 3..0
    };

endpackage

// File: rtl/sa_feed_sequencer_if.sv
// Control/handshake bundle between the top-level controller and the feed sequencer.
interface sa_feed_sequencer_if #(
    parameter int OPCNT_W = 8
);
    logic               start;
    logic               src_valid;
    logic               res_ready;
    logic               busy;
    logic               feed_en;
    logic [3:0]         cnt;
    logic [1:0]         sel;
    logic               acc_clr;
    logic               res_valid;
    logic [OPCNT_W-1:0] op_cnt;

    modport master (
        output start, src_valid, res_ready,
        input  busy, feed_en, cnt, sel, acc_clr, res_valid, op_cnt
    );

    modport slave (
        input  start, src_valid, res_ready,
        output busy, feed_en, cnt, sel, acc_clr, res_valid, op_cnt
    );
endinterface

// File: rtl/sa_sel_decode.sv
// Pure combinational feed-beat to operand-mux select map, shared with the datapath.
module sa_sel_decode
    import sa_pkg::*;
(
    input  logic [3:0] cnt_i,
    output logic [1:0] sel_o
);

    assign sel_o = SA_SEL_LUT[cnt_i];

endmodule

// File: rtl/sa_feed_sequencer.sv
// Sequences one 3x3 systolic-array operand feed, pipeline drain and result handshake.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start; all outputs quiet
//   ST_FEED   | issuing operand beats 0..FEED_LEN-1, stalling on !src_valid
//   ST_DRAIN  | waiting DRAIN_CYCLES cycles for the PE pipeline to settle
//   ST_RESULT | res_valid held until writeback accepts with res_ready
module sa_feed_sequencer
    import sa_pkg::*;
#(
    parameter int FEED_LEN     = SA_FEED_LEN,
    parameter int DRAIN_CYCLES = 3,
    parameter int OPCNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    sa_feed_sequencer_if.slave   bus
);

    localparam int         DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [3:0] LAST_CNT = 4'(FEED_LEN - 1);

    sa_state_e          state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DW-1:0]      drain_q, drain_d;
    logic [OPCNT_W-1:0] op_cnt_q, op_cnt_d;
    logic               feed_en;
    logic [1:0]         sel;

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            drain_q  <= '0;
            op_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            op_cnt_q <= op_cnt_d;
        end
    end

    // Next-state, counter update and beat-issue decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        op_cnt_d = op_cnt_q;
        feed_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_FEED;
                    cnt_d   = '0;
                end
            end
            ST_FEED: begin
                feed_en = bus.src_valid;
                if (feed_en) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DRAIN;
                        cnt_d   = '0;
                        drain_d = DW'(DRAIN_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_RESULT;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    state_d  = ST_IDLE;
                    op_cnt_d = op_cnt_q + OPCNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sa_sel_decode u_sel_decode (
        .cnt_i (cnt_q),
        .sel_o (sel)
    );

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.feed_en   = feed_en;
    assign bus.cnt       = cnt_q;
    assign bus.sel       = sel;
    // cnt is 0 only on the first beat of an operation, so this fires once even across stalls.
    assign bus.acc_clr   = feed_en && (cnt_q == 4'd0);
    assign bus.res_valid = (state_q == ST_RESULT);
    assign bus.op_cnt    = op_cnt_q;

endmodule

// File: tb/tb_sa_feed_sequencer.sv
// Self-checking bench for sa_feed_sequencer: vector table, directed corner cases, random run vs model.
module tb_sa_feed_sequencer;

    localparam int FEED_LEN = 9;
    localparam int DRAIN    = 3;
    localparam int OPW      = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sa_feed_sequencer_if #(.OPCNT_W(OPW)) bus();

    sa_feed_sequencer #(
        .FEED_LEN     (FEED_LEN),
        .DRAIN_CYCLES (DRAIN),
        .OPCNT_W      (OPW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model: op-level progress, not states
    bit m_busy;
    int m_beats;
    int m_after;
    int m_ops;
    int sched [16];

    // values sampled in the most recent step
    logic       s_busy, s_fe, s_ac, s_rv;
    logic [3:0] s_cnt;
    logic [1:0] s_sel;
    logic [7:0] s_op;

    typedef struct {
        bit st, sv, rr;
        bit busy, fe, ac, rv;
        int cnt, sel, op;
    } vec_t;
    vec_t vt [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit st, bit sv, bit rr, bit busy, bit fe, int cnt, int sel,
                                bit ac, bit rv, int op);
        vec_t v;
        v.st = st; v.sv = sv; v.rr = rr; v.busy = busy; v.fe = fe;
        v.cnt = cnt; v.sel = sel; v.ac = ac; v.rv = rv; v.op = op;
        return v;
    endfunction

    // One clock cycle: drive inputs, compare against model mid-cycle, advance model, cross the edge.
    task automatic step(input bit st, input bit sv, input bit rr, input bit r);
        bit in_feed, e_fe;
        int e_cnt;
        rst = r; bus.start = st; bus.src_valid = sv; bus.res_ready = rr;
        @(negedge clk);
        s_busy = bus.busy; s_fe = bus.feed_en; s_ac = bus.acc_clr; s_rv = bus.res_valid;
        s_cnt = bus.cnt; s_sel = bus.sel; s_op = bus.op_cnt;
        in_feed = m_busy && (m_beats < FEED_LEN);
        e_cnt   = in_feed ? m_beats : 0;
        e_fe    = in_feed && sv;
        check("busy",      32'(s_busy), 32'(m_busy));
        check("feed_en",   32'(s_fe),   32'(e_fe));
        check("cnt",       32'(s_cnt),  32'(e_cnt));
        check("sel",       32'(s_sel),  32'(sched[e_cnt]));
        check("acc_clr",   32'(s_ac),   32'(e_fe && (m_beats == 0)));
        check("res_valid", 32'(s_rv),   32'(m_busy && !in_feed && (m_after >= DRAIN)));
        check("op_cnt",    32'(s_op),   32'(m_ops % 256));
        if (r) begin
            m_busy = 0; m_beats = 0; m_after = 0; m_ops = 0;
        end else if (!m_busy) begin
            if (st) begin m_busy = 1; m_beats = 0; m_after = 0; end
        end else if (in_feed) begin
            if (sv) m_beats++;
        end else if (m_after >= DRAIN) begin
            if (rr) begin m_busy = 0; m_ops++; end
        end else begin
            m_after++;
        end
        @(posedge clk);
        #1;
    endtask

    // Feed with src_valid high until res_valid seen (handshake on that cycle if rr); returns step count.
    task automatic run_to_result(input bit st, input bit rr, output int n);
        n = -1;
        for (int k = 0; k < 40; k++) begin
            step(st, 1'b1, rr, 1'b0);
            if (s_rv) begin n = k; break; end
        end
        if (n < 0) check("result_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int t, rv_at, n, fe_cnt, rv_cycles, op0;
        sched = '{0, 0, 1, 0, 1, 2, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0};
        m_busy = 0; m_beats = 0; m_after = 0; m_ops = 0;

        vt[0]  = mk(0,1,1, 0,0,0,0,0,0,0);
        vt[1]  = mk(1,1,1, 0,0,0,0,0,0,0);
        vt[2]  = mk(0,1,1, 1,1,0,0,1,0,0);
        vt[3]  = mk(0,1,1, 1,1,1,0,0,0,0);
        vt[4]  = mk(0,1,1, 1,1,2,1,0,0,0);
        vt[5]  = mk(0,1,1, 1,1,3,0,0,0,0);
        vt[6]  = mk(0,1,1, 1,1,4,1,0,0,0);
        vt[7]  = mk(0,1,1, 1,1,5,2,0,0,0);
        vt[8]  = mk(0,1,1, 1,1,6,1,0,0,0);
        vt[9]  = mk(0,1,1, 1,1,7,2,0,0,0);
        vt[10] = mk(0,1,1, 1,1,8,2,0,0,0);
        vt[11] = mk(0,1,1, 1,0,0,0,0,0,0);
        vt[12] = mk(0,1,1, 1,0,0,0,0,0,0);
        vt[13] = mk(0,1,1, 1,0,0,0,0,0,0);
        vt[14] = mk(0,1,1, 1,0,0,0,0,1,0);
        vt[15] = mk(0,1,1, 0,0,0,0,0,0,1);

        rst = 1'b1; bus.start = 1'b1; bus.src_valid = 1'b0; bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // basic operation from the vector table; start at entry 1, res_valid at entry 14 (T+13)
        for (int i = 0; i < 16; i++) begin
            step(vt[i].st, vt[i].sv, vt[i].rr, 1'b0);
            check("tbl_busy",    32'(s_busy), 32'(vt[i].busy));
            check("tbl_feed_en", 32'(s_fe),   32'(vt[i].fe));
            check("tbl_cnt",     32'(s_cnt),  32'(vt[i].cnt));
            check("tbl_sel",     32'(s_sel),  32'(vt[i].sel));
            check("tbl_acc_clr", 32'(s_ac),   32'(vt[i].ac));
            check("tbl_res_vld", 32'(s_rv),   32'(vt[i].rv));
            check("tbl_op_cnt",  32'(s_op),   32'(vt[i].op));
        end

        // stall at cnt=4 for 3 cycles stretches the op by exactly 3
        step(1, 1, 1, 0);
        t = 1;
        for (int k = 0; k < 4; k++) begin step(0, 1, 1, 0); t++; end
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 1, 0); t++;
            check("stall_cnt", 32'(s_cnt), 32'd4);
            check("stall_sel", 32'(s_sel), 32'd1);
            check("stall_fe",  32'(s_fe),  32'd0);
            check("stall_ac",  32'(s_ac),  32'd0);
        end
        rv_at = -1;
        for (int k = 0; k < 40; k++) begin
            step(0, 1, 1, 0);
            if (s_rv) begin rv_at = t; break; end
            t++;
        end
        check("stall_len", 32'(rv_at), 32'd16);
        step(0, 0, 0, 0);

        // backpressure: res_ready low for 5 result cycles
        op0 = m_ops;
        step(1, 1, 0, 0);
        run_to_result(0, 0, n);
        rv_cycles = 1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0);
            rv_cycles += int'(s_rv);
            check("bp_busy", 32'(s_busy), 32'd1);
        end
        step(0, 0, 1, 0);
        rv_cycles += int'(s_rv);
        check("bp_busy", 32'(s_busy), 32'd1);
        check("bp_rv_cycles", 32'(rv_cycles), 32'd6);
        step(0, 0, 0, 0);
        check("bp_rv_drop", 32'(s_rv), 32'd0);
        check("bp_op_cnt", 32'(s_op), 32'(op0 + 1));

        // start held high through FEED/DRAIN/RESULT is ignored
        op0 = m_ops;
        step(1, 1, 1, 0);
        run_to_result(1, 1, n);
        step(0, 0, 0, 0);
        check("ign_busy", 32'(s_busy), 32'd0);
        check("ign_op_cnt", 32'(s_op), 32'(op0 + 1));

        // reset at cnt=6, then a fresh full feed
        step(1, 1, 1, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0);
        step(1, 1, 1, 1);
        check("rst_pre_cnt", 32'(s_cnt), 32'd6);
        step(0, 0, 0, 0);
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_cnt",  32'(s_cnt),  32'd0);
        check("rst_sel",  32'(s_sel),  32'd0);
        check("rst_op",   32'(s_op),   32'd0);
        step(1, 1, 1, 0);
        fe_cnt = 0;
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 1, 0);
            fe_cnt += int'(s_fe);
        end
        check("fresh_beats", 32'(fe_cnt), 32'd9);
        check("fresh_last_cnt", 32'(s_cnt), 32'd8);
        run_to_result(0, 1, n);
        check("fresh_drain", 32'(n), 32'(DRAIN));

        // 256 back-to-back ops from a cleared counter; op_cnt 255 -> 0
        step(0, 0, 0, 1);
        for (int i = 0; i < 256; i++) begin
            step(1, 1, 1, 0);
            check("b2b_op", 32'(s_op), 32'(i % 256));
            step(0, 1, 1, 0);
            check("b2b_first_beat", 32'(s_fe), 32'd1);
            run_to_result(0, 1, n);
        end
        step(0, 0, 0, 0);
        check("wrap_op", 32'(s_op), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) < 3), ($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
